// File: rtl/light_seq_pkg.sv
// Shared types and the step-code encoding for the light-pattern sequencer.
package light_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Code 0 is reserved for idle, so active steps start at 1.
  function automatic int seq_code(input int seq, input int step, input int seq_len);
    return seq * seq_len + step + 1;
  endfunction

endpackage

// File: rtl/light_sequencer_step_timer.sv
// Step dwell timer: latches the dwell length on load and flags the final cycle of a step.
module step_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [DIV_W-1:0] div_q, div_d;

  assign tc_o = (dwell_q == div_q);

  always_comb begin
    dwell_d = dwell_q;
    div_d   = div_q;
    if (load_i) begin
      dwell_d = '0;
      div_d   = div_i;
    end else if (clear_i) begin
      dwell_d = '0;
    end else if (run_i) begin
      // Wrapping at the terminal count keeps the full DIV_W range usable without overflow.
      dwell_d = tc_o ? '0 : dwell_q + DIV_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q <= '0;
      div_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Multi-channel light-pattern sequencer: priority-picks a request, steps through its
// code sequence with a programmable dwell, optionally loops, and reports busy/done.
module light_sequencer
  import light_seq_pkg::*;
#(
  parameter int NUM_SEQ = 3,
  parameter int SEQ_LEN = 3,
  parameter int DIV_W   = 8,
  parameter int OUT_W   = 4
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_SEQ-1:0]                              req,
  input  logic [DIV_W-1:0]                                div,
  input  logic                                            loop_en,
  input  logic                                            abort,
  output logic [OUT_W-1:0]                                y,
  output logic                                            busy,
  output logic [((NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1)-1:0] active,
  output logic                                            done
);

  localparam int SEL_W  = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);

  if ((2 ** OUT_W) <= (NUM_SEQ * SEQ_LEN)) begin : g_bad_out_w
    $error("light_sequencer: OUT_W too narrow for NUM_SEQ*SEQ_LEN step codes");
  end

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   seq_q, seq_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   pick;
  logic               tmr_load, tmr_clear, tmr_run, tmr_tc;

  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (tmr_load),
    .clear_i (tmr_clear),
    .run_i   (tmr_run),
    .div_i   (div),
    .tc_o    (tmr_tc)
  );

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    step_d    = step_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_run   = 1'b0;

    pick = '0;
    for (int i = 0; i < NUM_SEQ; i++) begin
      if (req[i]) pick = SEL_W'(i);
    end

    case (state_q)
      IDLE: begin
        if (!abort && (|req)) begin
          state_d  = RUN;
          seq_d    = pick;
          step_d   = '0;
          tmr_load = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          step_d    = '0;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          if (step_q == LAST_STEP) begin
            if (loop_en && req[seq_q]) begin
              step_d   = '0;
              tmr_load = 1'b1;
            end else begin
              state_d   = IDLE;
              step_d    = '0;
              done_d    = 1'b1;
              tmr_clear = 1'b1;
            end
          end else begin
            step_d  = step_q + STEP_W'(1);
            tmr_run = 1'b1;
          end
        end else begin
          tmr_run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      seq_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign active = busy ? seq_q : '0;
  assign done   = done_q;
  assign y      = busy ? OUT_W'(seq_code(int'(seq_q), int'(step_q), SEQ_LEN)) : '0;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: a vector table for the main flows plus
// hand-written reset, abort and maximum-dwell sequences.
module tb_light_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [7:0] div;
  logic       loop_en;
  logic       abort;
  logic [3:0] y;
  logic       busy;
  logic [1:0] active;
  logic       done;

  int checks = 0;
  int errors = 0;

  light_sequencer #(
    .NUM_SEQ(3), .SEQ_LEN(3), .DIV_W(8), .OUT_W(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .div     (div),
    .loop_en (loop_en),
    .abort   (abort),
    .y       (y),
    .busy    (busy),
    .active  (active),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [7:0] div;
    logic       loop_en;
    logic [3:0] y;
    logic       busy;
    logic [1:0] active;
    logic       done;
  } vec_t;

  vec_t vecs[36];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ey, input logic eb,
                           input logic [1:0] ea, input logic ed);
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".active"}, 32'(active), 32'(ea));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [2:0] r, input logic [7:0] d, input logic l,
                         input logic [3:0] ey, input logic eb, input logic [1:0] ea,
                         input logic ed);
    vecs[i] = '{req: r, div: d, loop_en: l, y: ey, busy: eb, active: ea, done: ed};
  endtask

  initial begin
    // Single pulse on channel 0, div=0: 1,2,3 then idle with done.
    set_vec(0,  3'b001, 8'd0, 1'b0, 4'd1, 1, 2'd0, 0);
    set_vec(1,  3'b000, 8'd0, 1'b0, 4'd2, 1, 2'd0, 0);
    set_vec(2,  3'b000, 8'd0, 1'b0, 4'd3, 1, 2'd0, 0);
    set_vec(3,  3'b000, 8'd0, 1'b0, 4'd0, 0, 2'd0, 1);
    set_vec(4,  3'b000, 8'd0, 1'b0, 4'd0, 0, 2'd0, 0);
    // All requests: highest wins, lower ones ignored, idle cycle before restart.
    set_vec(5,  3'b111, 8'd0, 1'b0, 4'd7, 1, 2'd2, 0);
    set_vec(6,  3'b011, 8'd0, 1'b0, 4'd8, 1, 2'd2, 0);
    set_vec(7,  3'b011, 8'd0, 1'b0, 4'd9, 1, 2'd2, 0);
    set_vec(8,  3'b111, 8'd0, 1'b0, 4'd0, 0, 2'd0, 1);
    set_vec(9,  3'b111, 8'd0, 1'b0, 4'd7, 1, 2'd2, 0);
    set_vec(10, 3'b000, 8'd0, 1'b0, 4'd8, 1, 2'd2, 0);
    set_vec(11, 3'b000, 8'd0, 1'b0, 4'd9, 1, 2'd2, 0);
    set_vec(12, 3'b000, 8'd0, 1'b0, 4'd0, 0, 2'd0, 1);
    set_vec(13, 3'b000, 8'd0, 1'b0, 4'd0, 0, 2'd0, 0);
    // div=2 on channel 1, div dropped to 0 mid-run must not change timing.
    set_vec(14, 3'b010, 8'd2, 1'b0, 4'd4, 1, 2'd1, 0);
    set_vec(15, 3'b000, 8'd0, 1'b0, 4'd4, 1, 2'd1, 0);
    set_vec(16, 3'b000, 8'd0, 1'b0, 4'd4, 1, 2'd1, 0);
    set_vec(17, 3'b000, 8'd0, 1'b0, 4'd5, 1, 2'd1, 0);
    set_vec(18, 3'b000, 8'd0, 1'b0, 4'd5, 1, 2'd1, 0);
    set_vec(19, 3'b000, 8'd0, 1'b0, 4'd5, 1, 2'd1, 0);
    set_vec(20, 3'b000, 8'd0, 1'b0, 4'd6, 1, 2'd1, 0);
    set_vec(21, 3'b000, 8'd0, 1'b0, 4'd6, 1, 2'd1, 0);
    set_vec(22, 3'b000, 8'd0, 1'b0, 4'd6, 1, 2'd1, 0);
    set_vec(23, 3'b000, 8'd0, 1'b0, 4'd0, 0, 2'd0, 1);
    set_vec(24, 3'b000, 8'd0, 1'b0, 4'd0, 0, 2'd0, 0);
    // Loop mode with req[0] held 7 cycles: three passes, single done.
    set_vec(25, 3'b001, 8'd0, 1'b1, 4'd1, 1, 2'd0, 0);
    set_vec(26, 3'b001, 8'd0, 1'b1, 4'd2, 1, 2'd0, 0);
    set_vec(27, 3'b001, 8'd0, 1'b1, 4'd3, 1, 2'd0, 0);
    set_vec(28, 3'b001, 8'd0, 1'b1, 4'd1, 1, 2'd0, 0);
    set_vec(29, 3'b001, 8'd0, 1'b1, 4'd2, 1, 2'd0, 0);
    set_vec(30, 3'b001, 8'd0, 1'b1, 4'd3, 1, 2'd0, 0);
    set_vec(31, 3'b001, 8'd0, 1'b1, 4'd1, 1, 2'd0, 0);
    set_vec(32, 3'b000, 8'd0, 1'b1, 4'd2, 1, 2'd0, 0);
    set_vec(33, 3'b000, 8'd0, 1'b1, 4'd3, 1, 2'd0, 0);
    set_vec(34, 3'b000, 8'd0, 1'b1, 4'd0, 0, 2'd0, 1);
    set_vec(35, 3'b000, 8'd0, 1'b0, 4'd0, 0, 2'd0, 0);

    reset   = 1'b0;
    req     = '0;
    div     = '0;
    loop_en = 1'b0;
    abort   = 1'b0;
    #12;
    check_all("reset", 4'd0, 0, 2'd0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_all("post_reset", 4'd0, 0, 2'd0, 0);

    for (int i = 0; i < 36; i++) begin
      req     = vecs[i].req;
      div     = vecs[i].div;
      loop_en = vecs[i].loop_en;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].y, vecs[i].busy, vecs[i].active, vecs[i].done);
    end

    // Asynchronous reset in the middle of a run (y=5).
    req = 3'b010; div = 8'd0; loop_en = 1'b0;
    tick();
    check("rst_run.y4", 32'(y), 32'd4);
    req = 3'b000;
    tick();
    check("rst_run.y5", 32'(y), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check_all("rst_async", 4'd0, 0, 2'd0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_all("rst_rel1", 4'd0, 0, 2'd0, 0);
    tick();
    check_all("rst_rel2", 4'd0, 0, 2'd0, 0);

    // Abort during y=8 with div=1.
    req = 3'b100; div = 8'd1;
    tick();
    check("abort_mid.y7a", 32'(y), 32'd7);
    req = 3'b000;
    tick();
    check("abort_mid.y7b", 32'(y), 32'd7);
    tick();
    check("abort_mid.y8", 32'(y), 32'd8);
    abort = 1'b1;
    tick();
    check_all("abort_mid.after", 4'd0, 0, 2'd0, 0);
    abort = 1'b0;
    tick();
    check_all("abort_mid.idle", 4'd0, 0, 2'd0, 0);

    // Abort on the terminal cycle of the last step suppresses done.
    req = 3'b001; div = 8'd0;
    tick();
    req = 3'b000;
    check("abort_tc.y1", 32'(y), 32'd1);
    tick();
    tick();
    check("abort_tc.y3", 32'(y), 32'd3);
    abort = 1'b1;
    tick();
    check_all("abort_tc.after", 4'd0, 0, 2'd0, 0);

    // Abort in IDLE beats a request.
    req = 3'b001;
    tick();
    check_all("abort_idle", 4'd0, 0, 2'd0, 0);
    abort = 1'b0;
    req   = 3'b000;
    tick();

    // Maximum dwell: 256 cycles per step with no overflow.
    req = 3'b001; div = 8'hFF;
    tick();
    req = 3'b000; div = 8'd0;
    check("maxdiv.first", 32'(y), 32'd1);
    for (int i = 0; i < 255; i++) tick();
    check("maxdiv.last_of_step0", 32'(y), 32'd1);
    tick();
    check("maxdiv.step1", 32'(y), 32'd2);
    abort = 1'b1;
    tick();
    check_all("maxdiv.abort", 4'd0, 0, 2'd0, 0);
    abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
